// File: rtl/anabellek_yanitlayici.sv
// ============================================================================
// Module  : anabellek_yanitlayici
// Brief   : Main-memory responder: serializes line reads/posted line writes
//           into a single-port word-wide store, one word per access slot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module anabellek_yanitlayici #(
  parameter int                         ADRES_GENISLIGI     = 32,
  parameter int                         SOZCUK_GENISLIGI    = 32,
  parameter int                         SATIR_SOZCUK_SAYISI = 4,
  parameter int                         BELLEK_SOZCUK       = 16384,
  parameter logic [ADRES_GENISLIGI-1:0] BASLANGIC_ADRESI    = 'h8000_0000,
  parameter int                         ERISIM_GECIKMESI    = 0,
  localparam int                        SATIR_GENISLIGI     = SATIR_SOZCUK_SAYISI * SOZCUK_GENISLIGI
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADRES_GENISLIGI-1:0] ram_adres_i,
  input  logic                       ram_istek_gecerli_i,
  input  logic                       ram_yaz_i,
  input  logic [SATIR_GENISLIGI-1:0] ram_yazilacak_veri_i,
  output logic [SATIR_GENISLIGI-1:0] ram_okunan_veri_o,
  output logic                       ram_hazir_o,
  output logic                       ram_grant_o,
  output logic                       mesgul_o
);

  localparam int IW = $clog2(BELLEK_SOZCUK);
  localparam int KW = (SATIR_SOZCUK_SAYISI > 1) ? $clog2(SATIR_SOZCUK_SAYISI) : 1;
  localparam int BW = (ERISIM_GECIKMESI > 0) ? $clog2(ERISIM_GECIKMESI + 1) : 1;

  localparam logic [1:0] BOSTA      = 2'd0;
  localparam logic [1:0] OKU        = 2'd1;
  localparam logic [1:0] YANIT      = 2'd2;
  localparam logic [1:0] YAZ_BOSALT = 2'd3;

  logic [1:0]                  durum_q, durum_d;
  logic [KW-1:0]               kelime_q, kelime_d;
  logic [BW-1:0]               bekle_q, bekle_d;
  logic [IW-1:0]               taban_q;
  logic [SATIR_GENISLIGI-1:0]  yaz_hat_q;
  logic [SATIR_GENISLIGI-1:0]  oku_hat_q;
  logic [SATIR_GENISLIGI-1:0]  okunan_q;
  logic [SOZCUK_GENISLIGI-1:0] bellek_q [BELLEK_SOZCUK];

  logic [IW-1:0]               w_taban;
  logic [IW-1:0]               w_erisim_adres;
  logic                        w_slot_son;
  logic                        w_kelime_son;
  logic                        w_bosta_yazma;
  logic [SOZCUK_GENISLIGI-1:0] w_okunan;
  logic [SOZCUK_GENISLIGI-1:0] w_yazilacak;
  logic [SATIR_GENISLIGI-1:0]  w_oku_hat;

  // Line-aligned word index; the cast to IW bits gives the modulo-depth wrap.
  assign w_taban        = IW'((ram_adres_i - BASLANGIC_ADRESI) >> 2)
                        & ~IW'(SATIR_SOZCUK_SAYISI - 1);
  assign w_erisim_adres = taban_q + IW'(kelime_q);
  assign w_slot_son     = (bekle_q == BW'(ERISIM_GECIKMESI));
  assign w_kelime_son   = (kelime_q == KW'(SATIR_SOZCUK_SAYISI - 1));
  assign w_okunan       = bellek_q[w_erisim_adres];
  assign w_yazilacak    = yaz_hat_q[kelime_q*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI];

  always_comb begin
    w_oku_hat = oku_hat_q;
    w_oku_hat[kelime_q*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI] = w_okunan;
  end

  always_comb begin
    durum_d  = durum_q;
    kelime_d = kelime_q;
    bekle_d  = bekle_q;
    case (durum_q)
      BOSTA: begin
        if (ram_istek_gecerli_i) begin
          durum_d  = ram_yaz_i ? YAZ_BOSALT : OKU;
          kelime_d = '0;
          bekle_d  = '0;
        end
      end
      OKU, YAZ_BOSALT: begin
        if (w_slot_son) begin
          bekle_d = '0;
          if (w_kelime_son) begin
            durum_d  = (durum_q == OKU) ? YANIT : BOSTA;
            kelime_d = '0;
          end else begin
            kelime_d = kelime_q + 1'b1;
          end
        end else begin
          bekle_d = bekle_q + 1'b1;
        end
      end
      YANIT:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q   <= BOSTA;
      kelime_q  <= '0;
      bekle_q   <= '0;
      taban_q   <= '0;
      yaz_hat_q <= '0;
      oku_hat_q <= '0;
      okunan_q  <= '0;
    end else begin
      durum_q  <= durum_d;
      kelime_q <= kelime_d;
      bekle_q  <= bekle_d;
      if (durum_q == BOSTA && ram_istek_gecerli_i) begin
        taban_q <= w_taban;
        if (ram_yaz_i) yaz_hat_q <= ram_yazilacak_veri_i;
      end
      // The visible line only changes once the whole line has been gathered.
      if (durum_q == OKU && w_slot_son) begin
        oku_hat_q <= w_oku_hat;
        if (w_kelime_son) okunan_q <= w_oku_hat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && durum_q == YAZ_BOSALT && w_slot_son)
      bellek_q[w_erisim_adres] <= w_yazilacak;
  end

  assign w_bosta_yazma     = (durum_q == BOSTA) && ram_istek_gecerli_i && ram_yaz_i && !rst_i;
  assign ram_grant_o       = w_bosta_yazma || (durum_q == OKU) || (durum_q == YANIT);
  assign ram_hazir_o       = w_bosta_yazma || (durum_q == YANIT);
  assign mesgul_o          = (durum_q != BOSTA);
  assign ram_okunan_veri_o = okunan_q;

endmodule

`default_nettype wire

// File: tb/tb_anabellek_yanitlayici.sv
// ============================================================================
// Module  : tb_anabellek_yanitlayici
// Brief   : Scoreboard bench for anabellek_yanitlayici (G=0 and G=2 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anabellek_yanitlayici;

  typedef struct {
    logic         yaz;
    logic [127:0] hat;
    int           cyc;
  } beklenen_t;

  logic         clk = 1'b0;
  logic         rst;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  beklenen_t    q0[$];
  beklenen_t    q1[$];

  logic [31:0]  i0_adres, i1_adres;
  logic         i0_istek, i1_istek, i0_yaz, i1_yaz;
  logic [127:0] i0_veri, i1_veri, o0_veri, o1_veri;
  logic         o0_hazir, o1_hazir, o0_grant, o1_grant, o0_mesgul, o1_mesgul;

  localparam logic [127:0] L1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] L2 = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF};
  localparam logic [127:0] L3 = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  anabellek_yanitlayici u0 (
    .clk_i(clk), .rst_i(rst), .ram_adres_i(i0_adres), .ram_istek_gecerli_i(i0_istek),
    .ram_yaz_i(i0_yaz), .ram_yazilacak_veri_i(i0_veri), .ram_okunan_veri_o(o0_veri),
    .ram_hazir_o(o0_hazir), .ram_grant_o(o0_grant), .mesgul_o(o0_mesgul)
  );

  anabellek_yanitlayici #(.BELLEK_SOZCUK(64), .ERISIM_GECIKMESI(2)) u1 (
    .clk_i(clk), .rst_i(rst), .ram_adres_i(i1_adres), .ram_istek_gecerli_i(i1_istek),
    .ram_yaz_i(i1_yaz), .ram_yazilacak_veri_i(i1_veri), .ram_okunan_veri_o(o1_veri),
    .ram_hazir_o(o1_hazir), .ram_grant_o(o1_grant), .mesgul_o(o1_mesgul)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string ad, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", ad, cyc, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic istek, input logic yaz,
                       input logic [31:0] a, input logic [127:0] v);
    if (d == 0) begin
      i0_istek = istek; i0_yaz = yaz; i0_adres = a; i0_veri = v;
    end else begin
      i1_istek = istek; i1_yaz = yaz; i1_adres = a; i1_veri = v;
    end
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic islem(input int d, input logic yaz, input logic [31:0] a,
                       input logic [127:0] hat, input int gecikme, input int tut);
    beklenen_t b;
    b.yaz = yaz;
    b.hat = hat;
    b.cyc = cyc + gecikme;
    if (d == 0) q0.push_back(b); else q1.push_back(b);
    drive(d, 1'b1, yaz, a, hat);
    repeat (tut) @(posedge clk);
    #1;
    drive(d, 1'b0, yaz, a, hat);
  endtask

  task automatic yanit_kontrol(input int d, input logic g, input logic m, input logic [127:0] v);
    beklenen_t b;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_hazir dut%0d: got hazir=1 at cycle %0d expected none", d, cyc);
      return;
    end
    b = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("hazir_cycle_dut%0d", d), cyc, b.cyc);
    chk($sformatf("grant_with_hazir_dut%0d", d), g, 1'b1);
    chk($sformatf("busy_kind_dut%0d", d), m, !b.yaz);
    if (!b.yaz) chk($sformatf("read_line_dut%0d", d), v, b.hat);
  endtask

  always @(negedge clk) begin
    if (o0_hazir) yanit_kontrol(0, o0_grant, o0_mesgul, o0_veri);
    if (o1_hazir) yanit_kontrol(1, o1_grant, o1_mesgul, o1_veri);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 128'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 128'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_grant", o0_grant, 1'b0);
    chk("reset_hazir", o0_hazir, 1'b0);
    chk("reset_mesgul", o0_mesgul, 1'b0);
    chk("reset_data", o0_veri, 128'h0);
    chk("reset_data_g2", o1_veri, 128'h0);
    @(posedge clk); #1;

    // Posted write, then a read issued while it drains.
    islem(0, 1'b1, 32'h8000_0010, L1, 0, 1);
    fork
      islem(0, 1'b0, 32'h8000_0010, L1, 9, 10);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("drain_mesgul", o0_mesgul, (i < 4));
          chk("drain_grant", o0_grant, 1'b0);
        end
      end
    join

    islem(0, 1'b0, 32'h8000_001C, L1, 5, 6);          // unaligned read
    islem(0, 1'b1, 32'h8001_0000, L2, 0, 1);          // wraps to index 0
    islem(0, 1'b0, 32'h8000_0000, L2, 9, 10);
    islem(0, 1'b0, 32'h8000_0010, L1, 5, 1);          // istek dropped early
    repeat (5) @(posedge clk); #1;

    // Reset during the second OKU cycle: no hazir, outputs cleared.
    drive(0, 1'b1, 1'b0, 32'h8000_0000, 128'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h8000_0000, 128'h0);
    @(negedge clk);
    chk("rst_mid_grant", o0_grant, 1'b0);
    chk("rst_mid_hazir", o0_hazir, 1'b0);
    chk("rst_mid_data", o0_veri, 128'h0);
    chk("rst_mid_mesgul", o0_mesgul, 1'b0);
    repeat (10) @(posedge clk); #1;
    islem(0, 1'b0, 32'h8000_0010, L1, 5, 6);          // store survives reset

    // G=2 instance: 12-cycle drain, read latency 13, grant window k+1..k+13.
    islem(1, 1'b1, 32'h8000_0020, L3, 0, 1);
    repeat (12) @(posedge clk); #1;
    fork
      islem(1, 1'b0, 32'h8000_0020, L3, 13, 14);
      begin
        @(negedge clk);
        chk("g2_grant_accept_cycle", o1_grant, 1'b0);
        for (int i = 1; i <= 13; i++) begin
          @(negedge clk);
          chk("g2_grant_window", o1_grant, 1'b1);
        end
      end
    join

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("missing_responses_dut0", q0.size(), 0);
    chk("missing_responses_dut1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
